// File: rtl/inst_rom_arb_pkg.sv
// Shared constants and state encoding for the inst_rom read-port arbiter.
package inst_rom_arb_pkg;

  localparam logic [31:0]  ZERO_WORD         = 32'h0000_0000;
  localparam int unsigned  INST_ADDR_BUS     = 32;
  localparam int unsigned  INST_BUS          = 32;
  localparam int unsigned  INST_MEM_NUM_LOG2 = 17;
  localparam int unsigned  ARB_STARVE_MAX    = 8;
  localparam int unsigned  PERF_CNT_W        = 32;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic [0:0] {
    S_IF_PRI  = 1'b0,
    S_DBG_PRI = 1'b1
  } arb_state_e;

endpackage

// File: rtl/inst_rom_arb_perf.sv
// Free-running grant/conflict counters for the inst_rom arbiter (wrap at 2^CNT_W).
module inst_rom_arb_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_gnt,
  input  logic             dbg_gnt,
  input  logic             conflict,
  output logic [CNT_W-1:0] perf_if_cnt,
  output logic [CNT_W-1:0] perf_dbg_cnt,
  output logic [CNT_W-1:0] perf_conflict_cnt
);

  // Count grants per requester and cycles where both requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_cnt       <= '0;
      perf_dbg_cnt      <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (if_gnt)   perf_if_cnt       <= perf_if_cnt + CNT_W'(1);
      if (dbg_gnt)  perf_dbg_cnt      <= perf_dbg_cnt + CNT_W'(1);
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/inst_rom_arb.sv
// Arbiter for the single combinational inst_rom read port, shared by the IF
// fetch path and the debug/boot-check reader. Grant is combinational, the
// read word comes back registered one cycle later.
// Optional: define INST_ROM_ARB_PERF_EN to add perf counter outputs.
module inst_rom_arb
  import inst_rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = INST_ADDR_BUS,
  parameter int unsigned DATA_W     = INST_BUS,
  parameter int unsigned MEM_LOG2   = INST_MEM_NUM_LOG2,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
`ifdef INST_ROM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_if_cnt,
  output logic [PERF_CNT_W-1:0] perf_dbg_cnt,
  output logic [PERF_CNT_W-1:0] perf_conflict_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;

  // Misaligned or beyond the ROM depth.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (MEM_LOG2 + 2)) != '0);
  endfunction

  // State and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF_PRI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant decision; no grants while reset is asserted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      case (state_q)
        S_IF_PRI: begin
          if (if_req) begin
            if_gnt = 1'b1;
            if (dbg_req) begin
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_d >= CNT_W'(STARVE_MAX)) state_d = S_DBG_PRI;
            end else begin
              cnt_d = '0;
            end
          end else begin
            dbg_gnt = dbg_req;
            cnt_d   = '0;
          end
        end
        S_DBG_PRI: begin
          // Either dbg takes its forced slot, or it gave up and IF proceeds.
          if (dbg_req) dbg_gnt = 1'b1;
          else         if_gnt  = if_req;
          cnt_d   = '0;
          state_d = S_IF_PRI;
        end
        default: begin
          state_d = S_IF_PRI;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ROM port mux; errored addresses are granted but never reach the ROM.
  always_comb begin
    sel_addr = '0;
    if (if_gnt)       sel_addr = if_addr;
    else if (dbg_gnt) sel_addr = dbg_addr;
    sel_err  = addr_err(sel_addr);
    rom_addr = sel_addr;
    rom_ce   = (if_gnt | dbg_gnt) & ~sel_err;
  end

  // Response registers: one-cycle rvalid pulse, rdata held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid  <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      dbg_rvalid <= 1'b0;
      dbg_err    <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      if_rvalid  <= if_gnt;
      if_err     <= if_gnt & sel_err;
      dbg_rvalid <= dbg_gnt;
      dbg_err    <= dbg_gnt & sel_err;
      if (if_gnt)  if_rdata  <= sel_err ? DATA_W'(ZERO_WORD) : rom_inst;
      if (dbg_gnt) dbg_rdata <= sel_err ? DATA_W'(ZERO_WORD) : rom_inst;
    end
  end

`ifdef INST_ROM_ARB_PERF_EN
  inst_rom_arb_perf #(
    .CNT_W (PERF_CNT_W)
  ) u_perf (
    .clk               (clk),
    .rst               (rst),
    .if_gnt            (if_gnt),
    .dbg_gnt           (dbg_gnt),
    .conflict          (rst & if_req & dbg_req),
    .perf_if_cnt       (perf_if_cnt),
    .perf_dbg_cnt      (perf_dbg_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_inst_rom_arb.sv
// Bench for inst_rom_arb: scoreboard of expected responses, popped by a
// negedge monitor; grant behaviour checked inline per scenario.
module tb_inst_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic        dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] if_rdata, dbg_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst;
`ifdef INST_ROM_ARB_PERF_EN
  logic [31:0] perf_if_cnt, perf_dbg_cnt, perf_conflict_cnt;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t dbg_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  always #5 clk = ~clk;

  inst_rom_arb dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_err    (dbg_err),
    .rom_ce     (rom_ce),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst)
`ifdef INST_ROM_ARB_PERF_EN
    ,
    .perf_if_cnt       (perf_if_cnt),
    .perf_dbg_cnt      (perf_dbg_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx + 32'd1) * 32'h9E37_79B9;
  endfunction

  function automatic rsp_t exp_rsp(input logic [31:0] a);
    rsp_t r;
    r.err  = (a[1:0] != 2'b00) || (a >= 32'h0008_0000);
    r.data = r.err ? 32'h0 : mem_word(a >> 2);
    return r;
  endfunction

  // ROM model: garbage when not enabled so a bypassed error path shows up.
  always_comb rom_inst = rom_ce ? mem_word({15'd0, rom_addr[18:2]}) : 32'hDEAD_BEEF;

  // Response scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (mon_en) begin
      checks++;
      if (if_rvalid !== (if_q.size() != 0)) begin
        failures++;
        $display("FAIL if_rvalid actual=%b expected=%b t=%0t", if_rvalid, if_q.size() != 0, $time);
        if (if_q.size() != 0) void'(if_q.pop_front());
      end else if (if_rvalid) begin
        e = if_q.pop_front();
        if ({if_rdata, if_err} !== e) begin
          failures++;
          $display("FAIL if_rsp actual=%h/%b expected=%h/%b t=%0t", if_rdata, if_err, e.data, e.err, $time);
        end
      end
      checks++;
      if (dbg_rvalid !== (dbg_q.size() != 0)) begin
        failures++;
        $display("FAIL dbg_rvalid actual=%b expected=%b t=%0t", dbg_rvalid, dbg_q.size() != 0, $time);
        if (dbg_q.size() != 0) void'(dbg_q.pop_front());
      end else if (dbg_rvalid) begin
        e = dbg_q.pop_front();
        if ({dbg_rdata, dbg_err} !== e) begin
          failures++;
          $display("FAIL dbg_rsp actual=%h/%b expected=%h/%b t=%0t", dbg_rdata, dbg_err, e.data, e.err, $time);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if_req  = 1'b0;
      dbg_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h0; dbg_req = 1'b1; dbg_addr = 32'h4;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, if_err, dbg_err, rom_ce} !== 7'b0 ||
        if_rdata !== 32'h0 || dbg_rdata !== 32'h0 || rom_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b%b%b%b%b%b%b/%h/%h/%h expected=all zero",
               if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, if_err, dbg_err, rom_ce, if_rdata, dbg_rdata, rom_addr);
    end
    @(negedge clk);
    rst = 1'b1; dbg_req = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    mon_en = 1'b1;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || dbg_gnt !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_grant actual=%b%b%b/%h expected=101/00000000", if_gnt, dbg_gnt, rom_ce, rom_addr);
    end
    if_q.push_back(exp_rsp(32'h0));
    idle(2);
  endtask

  task automatic test_if_stream();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'(k * 4);
      #1;
      checks++;
      if (if_gnt !== 1'b1 || rom_ce !== 1'b1 || rom_addr !== 32'(k * 4)) begin
        failures++;
        $display("FAIL if_stream_gnt k=%0d actual=%b%b/%h expected=11/%h", k, if_gnt, rom_ce, rom_addr, 32'(k * 4));
      end
      if_q.push_back(exp_rsp(32'(k * 4)));
    end
    idle(4);
    #1;
    checks++;
    if (if_rdata !== mem_word(32'd2)) begin
      failures++;
      $display("FAIL if_rdata_hold actual=%h expected=%h", if_rdata, mem_word(32'd2));
    end
  endtask

  task automatic test_starvation();
    logic [31:0] ia;
    logic        exp_d;
    ia = 32'h40;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if_req = 1'b1; dbg_req = 1'b1; if_addr = ia; dbg_addr = 32'h100;
      exp_d = ((k % 9) == 8);
      #1;
      checks++;
      if (if_gnt !== ~exp_d || dbg_gnt !== exp_d) begin
        failures++;
        $display("FAIL starve_gnt k=%0d actual=%b%b expected=%b%b", k, if_gnt, dbg_gnt, ~exp_d, exp_d);
      end
      if (exp_d) dbg_q.push_back(exp_rsp(32'h100));
      else begin
        if_q.push_back(exp_rsp(ia));
        ia = ia + 32'd4;
      end
    end
    idle(2);
  endtask

  task automatic test_errors();
    logic [31:0] da [2];
    logic [31:0] ia [2];
    da[0] = 32'h2; da[1] = 32'h4 << 17;
    ia[0] = 32'h0007_FFFC; ia[1] = 32'h1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if_req = 1'b0; dbg_req = 1'b1; dbg_addr = da[k];
      #1;
      checks++;
      if (dbg_gnt !== 1'b1 || if_gnt !== 1'b0 || rom_ce !== 1'b0) begin
        failures++;
        $display("FAIL dbg_err_gnt k=%0d actual=%b%b%b expected=100", k, dbg_gnt, if_gnt, rom_ce);
      end
      dbg_q.push_back(exp_rsp(da[k]));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      dbg_req = 1'b0; if_req = 1'b1; if_addr = ia[k];
      #1;
      checks++;
      if (if_gnt !== 1'b1 || rom_ce !== (k == 0)) begin
        failures++;
        $display("FAIL if_err_gnt k=%0d actual=%b%b expected=1%b", k, if_gnt, rom_ce, k == 0);
      end
      if_q.push_back(exp_rsp(ia[k]));
    end
    idle(3);
    #1;
    checks++;
    if (dbg_rdata !== 32'h0 || dbg_err !== 1'b0 || if_err !== 1'b0) begin
      failures++;
      $display("FAIL err_idle actual=%h/%b/%b expected=00000000/0/0", dbg_rdata, dbg_err, if_err);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'hC;
    #1;
    if_q.push_back(exp_rsp(32'hC));
    @(negedge clk);
    if_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid actual=%b/%h expected=0/00000000", if_rvalid, if_rdata);
    end
    if_q.delete();
    dbg_q.delete();
    @(negedge clk);
    if_req = 1'b1; dbg_req = 1'b1;
    @(negedge clk);
    if_req = 1'b0; dbg_req = 1'b0;
    rst = 1'b1;
    idle(3);
  endtask

`ifdef INST_ROM_ARB_PERF_EN
  task automatic test_perf();
    logic exp_d;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if_req = 1'b1; dbg_req = 1'b1; if_addr = 32'h200; dbg_addr = 32'h300;
      exp_d = ((k % 9) == 8);
      #1;
      if (exp_d) dbg_q.push_back(exp_rsp(32'h300));
      else       if_q.push_back(exp_rsp(32'h200));
    end
    idle(2);
    #1;
    checks++;
    if (perf_conflict_cnt !== 32'd10 || perf_if_cnt !== 32'd9 || perf_dbg_cnt !== 32'd1 ||
        perf_if_cnt + perf_dbg_cnt !== 32'd10) begin
      failures++;
      $display("FAIL perf_cnt actual=%0d/%0d/%0d expected=10/9/1", perf_conflict_cnt, perf_if_cnt, perf_dbg_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; if_req = 1'b0; dbg_req = 1'b0; if_addr = '0; dbg_addr = '0;
    test_reset();
    test_if_stream();
    test_starvation();
    test_errors();
    test_reset_mid();
`ifdef INST_ROM_ARB_PERF_EN
    test_perf();
`endif
    @(negedge clk);
    mon_en = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
